// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU stream arbiter.
//   chan_t    : channel id (0 = alu0, 1 = alu1)
//   CH_ALU0/1 : channel id constants
//   RUN_W     : width of the consecutive-grant run counter (weights 1..15)
package alu_arb_pkg;

  typedef logic chan_t;

  localparam chan_t CH_ALU0 = 1'b0;
  localparam chan_t CH_ALU1 = 1'b1;

  localparam int unsigned RUN_W = 4;

  function automatic chan_t other_chan(chan_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/rr_weight_sel.sv
// Combinational weighted round-robin selection.
// Ports:
//   owner_i    : channel currently holding the grant run
//   run_i      : consecutive beats already granted to owner_i
//   valid_i    : per-channel valid, indexed by channel id
//   weight0_i  : max run for ch0 while ch1 waits
//   weight1_i  : max run for ch1 while ch0 waits
//   sel_o      : selected channel (meaningful only when sel_ok_o)
//   sel_ok_o   : a selection exists this cycle
module rr_weight_sel
  import alu_arb_pkg::*;
(
  input  chan_t            owner_i,
  input  logic [RUN_W-1:0] run_i,
  input  logic [1:0]       valid_i,
  input  logic [RUN_W-1:0] weight0_i,
  input  logic [RUN_W-1:0] weight1_i,
  output chan_t            sel_o,
  output logic             sel_ok_o
);

  chan_t            other;
  logic             v_own;
  logic             v_oth;
  logic [RUN_W-1:0] w_own;

  always_comb begin
    other    = other_chan(owner_i);
    v_own    = valid_i[owner_i];
    v_oth    = valid_i[other];
    w_own    = (owner_i == CH_ALU1) ? weight1_i : weight0_i;
    sel_o    = owner_i;
    sel_ok_o = 1'b0;
    // Owner keeps the grant until its weight is used up, unless nobody else wants it.
    if (v_own && ((run_i < w_own) || !v_oth)) begin
      sel_ok_o = 1'b1;
    end else if (v_oth) begin
      sel_o    = other;
      sel_ok_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_stream_arbiter.sv
// Weighted round-robin merge of two ALU result streams into one registered
// valid/ready stream tagged with its source channel.
// Optional feature: define ALU_STREAM_ARB_CNT_EN to add per-channel accepted
// beat counters (cnt0, cnt1) with a synchronous clear (cnt_clear).
// Ports:
//   clk_clk, reset_reset_n     : clock, async active-low reset
//   alu{0,1}_data/valid/ready  : input streams (ready driven here)
//   out_data/channel/valid     : registered merged stream
//   out_ready                  : downstream accept
//   cnt_clear, cnt0, cnt1      : optional beat counters
module alu_stream_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WEIGHT0 = 2,
  parameter int unsigned WEIGHT1 = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
`ifdef ALU_STREAM_ARB_CNT_EN
  input  logic              cnt_clear,
  output logic [31:0]       cnt0,
  output logic [31:0]       cnt1,
`endif
  input  logic [DATA_W-1:0] alu0_data,
  input  logic              alu0_valid,
  output logic              alu0_ready,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu1_valid,
  output logic              alu1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_channel,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [RUN_W-1:0] W0 = RUN_W'(WEIGHT0);
  localparam logic [RUN_W-1:0] W1 = RUN_W'(WEIGHT1);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  chan_t             out_channel_q, out_channel_d;
  chan_t             owner_q, owner_d;
  logic [RUN_W-1:0]  run_q, run_d;

  logic             slot;
  chan_t            sel;
  logic             sel_ok;
  logic             xfer0;
  logic             xfer1;
  logic [RUN_W-1:0] w_own;

  assign slot = ~out_valid_q | out_ready;

  rr_weight_sel u_sel (
    .owner_i   (owner_q),
    .run_i     (run_q),
    .valid_i   ({alu1_valid, alu0_valid}),
    .weight0_i (W0),
    .weight1_i (W1),
    .sel_o     (sel),
    .sel_ok_o  (sel_ok)
  );

  // Reset gating keeps both readies low while reset is held, even though the
  // empty output register would otherwise open a slot.
  assign alu0_ready = reset_reset_n & slot & sel_ok & (sel == CH_ALU0);
  assign alu1_ready = reset_reset_n & slot & sel_ok & (sel == CH_ALU1);

  assign xfer0 = alu0_valid & alu0_ready;
  assign xfer1 = alu1_valid & alu1_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    owner_d       = owner_q;
    run_d         = run_q;
    w_own         = (owner_q == CH_ALU1) ? W1 : W0;
    if (xfer0 || xfer1) begin
      out_valid_d   = 1'b1;
      out_data_d    = (sel == CH_ALU1) ? alu1_data : alu0_data;
      out_channel_d = sel;
      if (sel == owner_q) begin
        // Saturate so a lone channel never wraps its run count.
        run_d = (run_q >= w_own) ? w_own : run_q + RUN_W'(1);
      end else begin
        owner_d = sel;
        run_d   = RUN_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= CH_ALU0;
      owner_q       <= CH_ALU0;
      run_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      owner_q       <= owner_d;
      run_q         <= run_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

`ifdef ALU_STREAM_ARB_CNT_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (xfer0) cnt0_d = cnt0_q + 32'd1;
      if (xfer1) cnt1_d = cnt1_q + 32'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_stream_arbiter.sv
// Self-checking bench for alu_stream_arbiter: directed phases plus a random
// phase, all checked cycle by cycle against a behavioural arbitration model.
module tb_alu_stream_arbiter;

  localparam int unsigned WEIGHT0 = 2;
  localparam int unsigned WEIGHT1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu0_data = '0;
  logic        alu0_valid = 1'b0;
  logic        alu0_ready;
  logic [31:0] alu1_data = '0;
  logic        alu1_valid = 1'b0;
  logic        alu1_ready;
  logic [31:0] out_data;
  logic        out_channel;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef ALU_STREAM_ARB_CNT_EN
  logic        cnt_clear = 1'b0;
  logic [31:0] cnt0;
  logic [31:0] cnt1;
  logic [31:0] m_c0;
  logic [31:0] m_c1;
`endif

  int npass = 0;
  int nchk  = 0;

  // Behavioural model: current output beat plus who has been granted how often in a row.
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_oc;
  int          m_owner;
  int          m_streak;

  // Data generators: per-channel base plus count of beats accepted so far.
  int          base0, base1, n0, n1;

  always #5 clk = ~clk;

  alu_stream_arbiter #(
    .DATA_W  (32),
    .WEIGHT0 (WEIGHT0),
    .WEIGHT1 (WEIGHT1)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
`ifdef ALU_STREAM_ARB_CNT_EN
    .cnt_clear     (cnt_clear),
    .cnt0          (cnt0),
    .cnt1          (cnt1),
`endif
    .alu0_data     (alu0_data),
    .alu0_valid    (alu0_valid),
    .alu0_ready    (alu0_ready),
    .alu1_data     (alu1_data),
    .alu1_valid    (alu1_valid),
    .alu1_ready    (alu1_ready),
    .out_data      (out_data),
    .out_channel   (out_channel),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic int wt(int c);
    return (c == 1) ? WEIGHT1 : WEIGHT0;
  endfunction

  // Channel the rules would grant for these valids, or -1 for none.
  function automatic int pick(bit v0, bit v1);
    bit v[2];
    int o;
    int x;
    v[0] = v0;
    v[1] = v1;
    o = m_owner;
    x = 1 - m_owner;
    if (v[o] && ((m_streak < wt(o)) || !v[x])) return o;
    if (v[x]) return x;
    return -1;
  endfunction

  task automatic model_reset();
    m_ov     = 1'b0;
    m_od     = '0;
    m_oc     = 1'b0;
    m_owner  = 0;
    m_streak = 0;
`ifdef ALU_STREAM_ARB_CNT_EN
    m_c0 = '0;
    m_c1 = '0;
`endif
  endtask

  // One clock: called just after a falling edge with valids/out_ready already set.
  task automatic step();
    bit slot;
    bit er0;
    bit er1;
    int g;
    alu0_data = base0 + n0;
    alu1_data = base1 + n1;
    #1;
    slot = !m_ov || out_ready;
    g    = pick(alu0_valid, alu1_valid);
    er0  = rst_n && slot && (g == 0);
    er1  = rst_n && slot && (g == 1);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_channel", 32'(out_channel), 32'(m_oc));
    end
    check("alu0_ready", 32'(alu0_ready), 32'(er0));
    check("alu1_ready", 32'(alu1_ready), 32'(er1));
`ifdef ALU_STREAM_ARB_CNT_EN
    check("cnt0", cnt0, m_c0);
    check("cnt1", cnt1, m_c1);
`endif
    @(posedge clk);
    if (rst_n) begin
`ifdef ALU_STREAM_ARB_CNT_EN
      if (cnt_clear) begin
        m_c0 = '0;
        m_c1 = '0;
      end else begin
        if (er0) m_c0 = m_c0 + 32'd1;
        if (er1) m_c1 = m_c1 + 32'd1;
      end
`endif
      if (er0 || er1) begin
        m_ov = 1'b1;
        m_od = er1 ? alu1_data : alu0_data;
        m_oc = er1;
        if (g == m_owner) begin
          m_streak = (m_streak + 1 > wt(g)) ? wt(g) : m_streak + 1;
        end else begin
          m_owner  = g;
          m_streak = 1;
        end
        if (er0) n0++;
        else     n1++;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    base0 = 32'h100;
    base1 = 32'h200;
    n0    = 0;
    n1    = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_channel", 32'(out_channel), 32'd0);
    check("rst_alu0_ready", 32'(alu0_ready), 32'd0);
    check("rst_alu1_ready", 32'(alu1_ready), 32'd0);
    rst_n = 1'b1;

    // Both channels saturated: expect channel pattern 0,0,1 repeating, no gaps
    alu0_valid = 1'b1;
    alu1_valid = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        check("pattern_valid", 32'(out_valid), 32'd1);
        check("pattern_chan", 32'(out_channel), 32'(((i - 1) % 3) == 2));
      end
      step();
    end

    // Only ch1 valid: 5 consecutive ch1 beats 0xA..0xE, then ch0 joins
    alu0_valid = 1'b0;
    base1 = 32'hA;
    n1    = 0;
    repeat (5) step();
    check("ch1_burst_last", out_data, 32'hE);
    alu0_valid = 1'b1;
    repeat (3) step();

    // Back-pressure for 4 cycles with a beat held
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    repeat (6) step();

    // Alternating out_ready with both valid
    for (int i = 0; i < 16; i++) begin
      out_ready = i[0];
      step();
    end

    // Reset asserted asynchronously between edges while a beat is held
    out_ready = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready0", 32'(alu0_ready), 32'd0);
    check("async_rst_ready1", 32'(alu1_ready), 32'd0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    #1;
    check("first_grant_ch0", 32'(alu0_ready), 32'd1);
    step();
    repeat (4) step();

`ifdef ALU_STREAM_ARB_CNT_EN
    // Counters: clear, then 7 ch0 and 3 ch1 beats, then clear during an accept
    alu0_valid = 1'b0;
    alu1_valid = 1'b0;
    step();
    cnt_clear = 1'b1;
    step();
    cnt_clear  = 1'b0;
    alu0_valid = 1'b1;
    repeat (7) step();
    alu0_valid = 1'b0;
    alu1_valid = 1'b1;
    repeat (3) step();
    alu1_valid = 1'b0;
    step();
    check("cnt0_seven", cnt0, 32'd7);
    check("cnt1_three", cnt1, 32'd3);
    alu0_valid = 1'b1;
    cnt_clear  = 1'b1;
    step();
    cnt_clear  = 1'b0;
    alu0_valid = 1'b0;
    check("cnt0_cleared", cnt0, 32'd0);
    check("cnt1_cleared", cnt1, 32'd0);
    step();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      alu0_valid = 1'($urandom_range(0, 1));
      alu1_valid = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 9) < 7);
      base0      = $urandom;
      base1      = $urandom;
`ifdef ALU_STREAM_ARB_CNT_EN
      cnt_clear  = ($urandom_range(0, 31) == 0);
`endif
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
